freq_gate_sequencer: RTL and testbench

//  Sequencer/auto-ranger for frequency_counter. Drives its Ncycles gate length and active-low reset,

---
 rtl/freq_gate_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_freq_gate_sequencer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_gate_sequencer.sv
// Gate sequencer and auto-ranger wrapped around a frequency_counter.
// Arms the counter, drops stale samples and publishes one result per measurement.
module freq_gate_sequencer #(
  parameter int          GATE_MIN_LOG2 = 10,
  parameter int          GATE_MAX_LOG2 = 27,
  parameter logic [31:0] CNT_LO        = 32'd1000,
  parameter logic [31:0] CNT_HI        = 32'h2000_0000,
  parameter int          ARM_CYCLES    = 4,
  parameter int          DISCARD       = 1,
  parameter int          TO_SLACK      = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        continuous,
  input  logic        auto_range,
  input  logic [4:0]  gate_log2_init,
  output logic [31:0] fc_Ncycles,
  output logic        fc_rst,
  input  logic [31:0] fc_count_tdata,
  input  logic        fc_count_tvalid,
  output logic [31:0] result,
  output logic [4:0]  result_gate_log2,
  output logic        result_valid,
  output logic        busy,
  output logic        err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARM  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_EVAL = 2'd3;

  localparam logic [4:0]  GMIN     = 5'(GATE_MIN_LOG2);
  localparam logic [4:0]  GMAX     = 5'(GATE_MAX_LOG2);
  localparam logic [7:0]  ARM_LAST = 8'(ARM_CYCLES - 1);
  localparam logic [7:0]  DISC_N   = 8'(DISCARD);
  localparam logic [31:0] SLACK    = 32'(TO_SLACK);

  logic [1:0]  state, state_n;
  logic [4:0]  gate, gate_n;
  logic        cont, cont_n;
  logic        auto_r, auto_n;
  logic        stop_pend, stop_pend_n;
  logic [7:0]  arm_cnt, arm_cnt_n;
  logic [7:0]  disc_cnt, disc_cnt_n;
  logic [31:0] timer, timer_n;
  logic [31:0] sample, sample_n;
  logic        publish;
  logic        err_set;
  logic        err_clr;

  logic [4:0]  init_cl;
  logic [31:0] limit;
  logic [31:0] timer_inc;

  assign init_cl = (gate_log2_init < GMIN) ? GMIN :
                   (gate_log2_init > GMAX) ? GMAX :
                   gate_log2_init;

  // Timeout allows two full gates plus slack before giving up.
  assign limit     = (32'd1 << (gate + 5'd1)) + SLACK;
  assign timer_inc = timer + 32'd1;

  always_comb begin
    state_n     = state;
    gate_n      = gate;
    cont_n      = cont;
    auto_n      = auto_r;
    stop_pend_n = stop_pend;
    arm_cnt_n   = arm_cnt;
    disc_cnt_n  = disc_cnt;
    timer_n     = timer;
    sample_n    = sample;
    publish     = 1'b0;
    err_set     = 1'b0;
    err_clr     = 1'b0;
    unique case (state)
      S_IDLE: begin
        stop_pend_n = 1'b0;
        if (start && !stop) begin
          cont_n    = continuous;
          auto_n    = auto_range;
          gate_n    = init_cl;
          err_clr   = 1'b1;
          arm_cnt_n = 8'd0;
          state_n   = S_ARM;
        end
      end
      S_ARM: begin
        if (stop) stop_pend_n = 1'b1;
        if (arm_cnt == ARM_LAST) begin
          if (stop_pend || stop) begin
            stop_pend_n = 1'b0;
            state_n     = S_IDLE;
          end else begin
            disc_cnt_n = 8'd0;
            timer_n    = 32'd0;
            state_n    = S_WAIT;
          end
        end else begin
          arm_cnt_n = arm_cnt + 8'd1;
        end
      end
      S_WAIT: begin
        if (stop) begin
          state_n = S_IDLE;
        end else if (fc_count_tvalid && disc_cnt >= DISC_N) begin
          sample_n = fc_count_tdata;
          state_n  = S_EVAL;
        end else begin
          if (fc_count_tvalid) disc_cnt_n = disc_cnt + 8'd1;
          if (timer_inc == limit) begin
            err_set = 1'b1;
            state_n = S_IDLE;
          end else begin
            timer_n = timer_inc;
          end
        end
      end
      S_EVAL: begin
        stop_pend_n = stop_pend || stop;
        if (auto_r && sample < CNT_LO && gate < GMAX) begin
          gate_n    = gate + 5'd1;
          arm_cnt_n = 8'd0;
          state_n   = S_ARM;
        end else if (auto_r && sample > CNT_HI && gate > GMIN) begin
          gate_n    = gate - 5'd1;
          arm_cnt_n = 8'd0;
          state_n   = S_ARM;
        end else begin
          publish = 1'b1;
          // Continuous mode keeps the counter running: no re-arm, no discard.
          if (cont && !stop && !stop_pend) begin
            timer_n = 32'd0;
            state_n = S_WAIT;
          end else begin
            stop_pend_n = 1'b0;
            state_n     = S_IDLE;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state            <= S_IDLE;
      gate             <= GMIN;
      cont             <= 1'b0;
      auto_r           <= 1'b0;
      stop_pend        <= 1'b0;
      arm_cnt          <= 8'd0;
      disc_cnt         <= 8'd0;
      timer            <= 32'd0;
      sample           <= 32'd0;
      fc_Ncycles       <= 32'd1 << GMIN;
      fc_rst           <= 1'b0;
      result           <= 32'd0;
      result_gate_log2 <= 5'd0;
      result_valid     <= 1'b0;
      busy             <= 1'b0;
      err              <= 1'b0;
    end else begin
      state        <= state_n;
      gate         <= gate_n;
      cont         <= cont_n;
      auto_r       <= auto_n;
      stop_pend    <= stop_pend_n;
      arm_cnt      <= arm_cnt_n;
      disc_cnt     <= disc_cnt_n;
      timer        <= timer_n;
      sample       <= sample_n;
      fc_Ncycles   <= 32'd1 << gate_n;
      // Counter stays out of reset through EVAL so continuous mode never re-arms.
      fc_rst       <= (state_n == S_WAIT) || (state_n == S_EVAL);
      busy         <= (state_n != S_IDLE);
      result_valid <= publish;
      if (publish) begin
        result           <= sample;
        result_gate_log2 <= gate;
      end
      if (err_clr)      err <= 1'b0;
      else if (err_set) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_freq_gate_sequencer.sv
// Directed bench for freq_gate_sequencer with a behavioural frequency_counter
// and a result scoreboard.
module tb_freq_gate_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        stop;
  logic        continuous;
  logic        auto_range;
  logic [4:0]  gate_log2_init;
  logic [31:0] fc_Ncycles;
  logic        fc_rst;
  logic [31:0] fc_count_tdata;
  logic        fc_count_tvalid;
  logic [31:0] result;
  logic [4:0]  result_gate_log2;
  logic        result_valid;
  logic        busy;
  logic        err;

  freq_gate_sequencer #(
    .GATE_MIN_LOG2(2),
    .GATE_MAX_LOG2(6),
    .CNT_LO(32'd100),
    .CNT_HI(32'd1000),
    .ARM_CYCLES(4),
    .DISCARD(1),
    .TO_SLACK(64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .stop(stop),
    .continuous(continuous),
    .auto_range(auto_range),
    .gate_log2_init(gate_log2_init),
    .fc_Ncycles(fc_Ncycles),
    .fc_rst(fc_rst),
    .fc_count_tdata(fc_count_tdata),
    .fc_count_tvalid(fc_count_tvalid),
    .result(result),
    .result_gate_log2(result_gate_log2),
    .result_valid(result_valid),
    .busy(busy),
    .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] cnt;
    logic [4:0]  gate;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] src_q[$];
  int          checks = 0;
  int          errors = 0;
  int          pulses = 0;
  int          rises  = 0;
  logic        prev_rst = 1'b0;
  int          mcnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Counter model: one sample per gate while out of reset.
  always @(negedge clk) begin
    fc_count_tvalid = 1'b0;
    if (!fc_rst) begin
      mcnt = 0;
    end else begin
      mcnt++;
      if (mcnt >= int'(fc_Ncycles) && src_q.size() > 0) begin
        fc_count_tdata  = src_q.pop_front();
        fc_count_tvalid = 1'b1;
        mcnt = 0;
      end
    end
  end

  always @(posedge clk) begin
    #2;
    if (fc_rst && !prev_rst) rises++;
    prev_rst = fc_rst;
    if (result_valid) begin
      exp_t e;
      pulses++;
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("result", result, e.cnt);
        chk("result_gate", 32'(result_gate_log2), 32'(e.gate));
      end
    end
  end

  task automatic do_start(input logic c, input logic a, input logic [4:0] g);
    @(negedge clk);
    start = 1'b1;
    continuous = c;
    auto_range = a;
    gate_log2_init = g;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 2000; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    chk(tag, 32'(busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed hang expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int p0;
    int r0;
    rst = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    continuous = 1'b0;
    auto_range = 1'b0;
    gate_log2_init = 5'd0;
    fc_count_tdata = 32'd0;
    fc_count_tvalid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_fc_rst", 32'(fc_rst), 32'd0);
    chk("rst_ncycles", fc_Ncycles, 32'd4);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_rgate", 32'(result_gate_log2), 32'd0);
    chk("rst_valid", 32'(result_valid), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Fixed gate, first sample dropped.
    src_q = '{32'd20, 32'd20};
    exp_q.push_back('{cnt: 32'd20, gate: 5'd4});
    p0 = pulses;
    do_start(1'b0, 1'b0, 5'd4);
    chk("t2_ncycles", fc_Ncycles, 32'd16);
    n = 0;
    for (int i = 0; i < 50; i++) begin
      if (busy && !fc_rst) n++;
      else break;
      @(negedge clk);
    end
    chk("t2_arm_low", 32'(n), 32'd4);
    wait_idle("t2_idle");
    chk("t2_pulses", 32'(pulses - p0), 32'd1);
    chk("t2_src_empty", 32'(src_q.size()), 32'd0);

    // Auto-range up two steps.
    src_q = '{32'd7, 32'd30, 32'd7, 32'd60, 32'd7, 32'd120};
    exp_q.push_back('{cnt: 32'd120, gate: 5'd5});
    r0 = rises;
    do_start(1'b0, 1'b1, 5'd3);
    wait_idle("t3_idle");
    @(negedge clk);
    chk("t3_arms", 32'(rises - r0), 32'd3);
    chk("t3_ncycles", fc_Ncycles, 32'd32);
    chk("t3_src_empty", 32'(src_q.size()), 32'd0);

    // Clamped gates publish out-of-range counts.
    src_q = '{32'd7, 32'd5};
    exp_q.push_back('{cnt: 32'd5, gate: 5'd6});
    do_start(1'b0, 1'b1, 5'd6);
    wait_idle("t4a_idle");
    src_q = '{32'd7, 32'd5000};
    exp_q.push_back('{cnt: 32'd5000, gate: 5'd2});
    do_start(1'b0, 1'b1, 5'd2);
    wait_idle("t4b_idle");
    chk("t4_src_empty", 32'(src_q.size()), 32'd0);

    // Init above max clamps; stop during ARM gives no result.
    r0 = rises;
    p0 = pulses;
    do_start(1'b0, 1'b0, 5'd31);
    chk("t4c_ncycles", fc_Ncycles, 32'd64);
    pulse_stop();
    wait_idle("t4c_idle");
    repeat (3) @(negedge clk);
    chk("t4c_no_wait", 32'(rises - r0), 32'd0);
    chk("t4c_no_pulse", 32'(pulses - p0), 32'd0);

    // Timeout with no samples.
    do_start(1'b0, 1'b0, 5'd3);
    for (int i = 0; i < 50; i++) begin
      if (fc_rst) break;
      @(negedge clk);
    end
    n = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      n++;
      if (err) break;
    end
    chk("t5_to_cycles", 32'(n), 32'd80);
    chk("t5_err", 32'(err), 32'd1);
    chk("t5_busy", 32'(busy), 32'd0);
    src_q = '{32'd7, 32'd9};
    exp_q.push_back('{cnt: 32'd9, gate: 5'd3});
    do_start(1'b0, 1'b0, 5'd3);
    chk("t5_err_clr", 32'(err), 32'd0);
    wait_idle("t5_idle");

    // Continuous mode then stop in WAIT.
    src_q = '{32'd200, 32'd200, 32'd200};
    exp_q.push_back('{cnt: 32'd200, gate: 5'd2});
    exp_q.push_back('{cnt: 32'd200, gate: 5'd2});
    p0 = pulses;
    r0 = rises;
    do_start(1'b1, 1'b0, 5'd2);
    for (int i = 0; i < 200; i++) begin
      if (pulses - p0 >= 2) break;
      @(negedge clk);
    end
    chk("t6_two_pulses", 32'(pulses - p0), 32'd2);
    chk("t6_no_rearm", 32'(rises - r0), 32'd1);
    repeat (3) @(negedge clk);
    chk("t6_busy_wait", 32'(busy), 32'd1);
    pulse_stop();
    repeat (20) @(negedge clk);
    chk("t6_stopped", 32'(busy), 32'd0);
    chk("t6_no_more", 32'(pulses - p0), 32'd2);
    chk("t6_err", 32'(err), 32'd0);
    chk("t6_fc_rst", 32'(fc_rst), 32'd0);

    // start together with stop is ignored.
    @(negedge clk);
    start = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_ss_busy", 32'(busy), 32'd0);
    chk("t6_ss_fc_rst", 32'(fc_rst), 32'd0);
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
